// File: rtl/boot_run_ctrl.sv
// Program-run sequencer: streams a byte image into the instruction ROM with the core
// held in reset, then releases the core and runs it until halt or a cycle budget.
module boot_run_ctrl #(
  parameter int unsigned ADDR_BITS  = 10,
  parameter int unsigned MAX_CYCLES = 2500
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           in_data,
  input  logic                 in_last,
  output logic                 rom_we,
  output logic [ADDR_BITS-1:0] rom_addr,
  output logic [7:0]           rom_wdata,
  output logic                 core_rst,
  input  logic                 core_halt,
  output logic [31:0]          cycle_count,
  output logic                 done,
  output logic                 timeout,
  output logic                 truncated
);

  localparam int unsigned CNT_W = 32;
  localparam logic [ADDR_BITS-1:0] PTR_LAST  = '1;
  localparam logic [CNT_W-1:0]     CNT_LIMIT = CNT_W'(MAX_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RELEASE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_BITS-1:0]   ptr_q, ptr_d;
  logic                   in_ready_d;
  logic                   rom_we_d;
  logic [ADDR_BITS-1:0]   rom_addr_d;
  logic [7:0]             rom_wdata_d;
  logic                   core_rst_d;
  logic [CNT_W-1:0]       cycle_count_d;
  logic [CNT_W-1:0]       cnt_inc;
  logic                   done_d;
  logic                   timeout_d;
  logic                   truncated_d;

  // Saturating increment of the run counter.
  assign cnt_inc = (&cycle_count) ? cycle_count : cycle_count + CNT_W'(1);

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    rom_we_d      = 1'b0;
    rom_addr_d    = rom_addr;
    rom_wdata_d   = rom_wdata;
    cycle_count_d = cycle_count;
    timeout_d     = timeout;
    truncated_d   = truncated;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d       = S_LOAD;
          ptr_d         = '0;
          cycle_count_d = '0;
          timeout_d     = 1'b0;
          truncated_d   = 1'b0;
        end
      end
      S_LOAD: begin
        if (in_valid && in_ready) begin
          rom_we_d    = 1'b1;
          rom_addr_d  = ptr_q;
          rom_wdata_d = in_data;
          ptr_d       = ptr_q + ADDR_BITS'(1);
          if (in_last) begin
            state_d = S_RELEASE;
          end else if (ptr_q == PTR_LAST) begin
            // ROM full before the stream ended: stop here rather than wrap.
            truncated_d = 1'b1;
            state_d     = S_RELEASE;
          end
        end
      end
      S_RELEASE: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        cycle_count_d = cnt_inc;
        if (core_halt) begin
          state_d   = S_DONE;
          timeout_d = 1'b0;
        end else if (cnt_inc >= CNT_LIMIT) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    in_ready_d = (state_d == S_LOAD);
    core_rst_d = (state_d != S_RUN);
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      in_ready    <= 1'b0;
      rom_we      <= 1'b0;
      rom_addr    <= '0;
      rom_wdata   <= '0;
      core_rst    <= 1'b1;
      cycle_count <= '0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      truncated   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      in_ready    <= in_ready_d;
      rom_we      <= rom_we_d;
      rom_addr    <= rom_addr_d;
      rom_wdata   <= rom_wdata_d;
      core_rst    <= core_rst_d;
      cycle_count <= cycle_count_d;
      done        <= done_d;
      timeout     <= timeout_d;
      truncated   <= truncated_d;
    end
  end

endmodule

// File: tb/tb_boot_run_ctrl.sv
// Scoreboarded bench for boot_run_ctrl: a stimulus thread queues expected ROM writes and
// run outcomes, and an independent monitor checks them as the DUT presents them.
module tb_boot_run_ctrl;

  localparam int unsigned ADDR_BITS  = 4;
  localparam int unsigned MAX_CYCLES = 40;
  localparam int          DEPTH      = 1 << ADDR_BITS;
  localparam int          MAXC       = int'(MAX_CYCLES);

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [7:0]           in_data = 8'h00;
  logic                 in_last = 1'b0;
  logic                 rom_we;
  logic [ADDR_BITS-1:0] rom_addr;
  logic [7:0]           rom_wdata;
  logic                 core_rst;
  logic                 core_halt = 1'b0;
  logic [31:0]          cycle_count;
  logic                 done;
  logic                 timeout;
  logic                 truncated;

  boot_run_ctrl #(.ADDR_BITS(ADDR_BITS), .MAX_CYCLES(MAX_CYCLES)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
    .core_rst(core_rst), .core_halt(core_halt),
    .cycle_count(cycle_count), .done(done), .timeout(timeout), .truncated(truncated)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; int data; } wr_t;
  typedef struct { longint count; int tmo; int trunc; } res_t;

  wr_t  exp_wr[$];
  res_t exp_res[$];
  int   checks = 0;
  int   failures = 0;
  logic [7:0] prog [0:31];

  function automatic void chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: compares ROM writes and run outcomes against the queued expectations.
  logic prev_done = 1'b0;
  wr_t  mw;
  res_t mr;
  always @(negedge clk) begin
    if (rom_we) begin
      if (exp_wr.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr=%0d data=%0d expected no write", rom_addr, rom_wdata);
      end else begin
        mw = exp_wr.pop_front();
        chk("wr_addr", longint'(rom_addr), longint'(mw.addr));
        chk("wr_data", longint'(rom_wdata), longint'(mw.data));
      end
    end
    if (done && !prev_done) begin
      if (exp_res.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 expected no run outcome");
      end else begin
        mr = exp_res.pop_front();
        chk("run_count", longint'(cycle_count), mr.count);
        chk("run_timeout", longint'(timeout), longint'(mr.tmo));
        chk("run_truncated", longint'(truncated), longint'(mr.trunc));
        chk("done_core_rst", longint'(core_rst), 1);
      end
    end
    prev_done = done;
  end

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_res.delete();
    @(negedge clk);
    chk("rst_in_ready", longint'(in_ready), 0);
    chk("rst_rom_we", longint'(rom_we), 0);
    chk("rst_rom_addr", longint'(rom_addr), 0);
    chk("rst_rom_wdata", longint'(rom_wdata), 0);
    chk("rst_core_rst", longint'(core_rst), 1);
    chk("rst_count", longint'(cycle_count), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_timeout", longint'(timeout), 0);
    chk("rst_truncated", longint'(truncated), 0);
    chk("rst_pending_writes", longint'(exp_wr.size()), 0);
    exp_wr.delete();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("load_in_ready", longint'(in_ready), 1);
    chk("load_core_rst", longint'(core_rst), 1);
    chk("load_done_clr", longint'(done), 0);
    chk("load_count_clr", longint'(cycle_count), 0);
    chk("load_flags_clr", longint'({timeout, truncated}), 0);
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit last, input int gap, input int addr);
    wr_t w;
    int  waited;
    bit  hs;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    w.addr = addr;
    w.data = int'(d);
    exp_wr.push_back(w);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    hs = 1'b0;
    waited = 0;
    while (!hs && waited < 50) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk); #1;
      waited++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!hs) begin
      checks++;
      failures++;
      $display("FAIL handshake_timeout: got in_ready=0 for 50 cycles expected accept of addr %0d", addr);
    end
  endtask

  // gap_mode: 0 back-to-back, 1 one idle cycle per byte, 2 random idle cycles.
  task automatic load_prog(input int k, input bit trunc, input int gap_mode);
    int gap;
    pulse_start();
    for (int i = 0; i < k; i++) begin
      gap = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 2));
      send_byte(prog[i], !trunc && (i == k - 1), gap, i);
    end
  endtask

  // Called right after the terminating byte; halt_at > MAX_CYCLES means never halt.
  task automatic run_and_check(input int halt_at, input bit trunc);
    res_t r;
    int   waited;
    r.count = (halt_at <= MAXC) ? longint'(halt_at) : longint'(MAXC);
    r.tmo   = (halt_at <= MAXC) ? 0 : 1;
    r.trunc = int'(trunc);
    exp_res.push_back(r);
    // Extra stream bytes past the end must stall and never reach the ROM.
    in_valid = 1'b1;
    in_data  = 8'($urandom);
    @(negedge clk);
    chk("release_in_ready", longint'(in_ready), 0);
    chk("release_core_rst", longint'(core_rst), 1);
    @(posedge clk); #1;
    start = 1'b1;
    @(negedge clk);
    chk("run_core_rst", longint'(core_rst), 0);
    chk("run_in_ready", longint'(in_ready), 0);
    if (halt_at == 1) core_halt = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b0;
    if (halt_at == 1) begin
      core_halt = 1'b0;
    end else if (halt_at <= MAXC) begin
      repeat (halt_at - 2) begin @(posedge clk); #1; end
      core_halt = 1'b1;
      @(posedge clk); #1;
      core_halt = 1'b0;
    end
    waited = 0;
    while (!done && waited < MAXC + 10) begin
      @(negedge clk);
      waited++;
    end
    chk("done_seen", longint'(done), 1);
    // DONE must hold its results even with halt asserted.
    core_halt = 1'b1;
    repeat (3) @(negedge clk);
    chk("hold_done", longint'(done), 1);
    chk("hold_count", longint'(cycle_count), r.count);
    chk("hold_core_rst", longint'(core_rst), 1);
    core_halt = 1'b0;
    chk("writes_drained", longint'(exp_wr.size()), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int k, h, gm;
    bit tr;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Fixed 8-byte image, halt on the 37th run cycle.
    for (int i = 0; i < 8; i++) prog[i] = ((i % 4) == 0) ? 8'h13 : 8'h00;
    load_prog(8, 1'b0, 0);
    run_and_check(37, 1'b0);

    // Toggled in_valid during load.
    for (int i = 0; i < 12; i++) prog[i] = 8'($urandom);
    load_prog(12, 1'b0, 1);
    run_and_check(5, 1'b0);

    // Budget expiry, then halt coinciding with the last budget cycle.
    for (int i = 0; i < 3; i++) prog[i] = 8'($urandom);
    load_prog(3, 1'b0, 0);
    run_and_check(MAXC + 1, 1'b0);
    load_prog(3, 1'b0, 2);
    run_and_check(MAXC, 1'b0);

    // Overlong stream with no last: fills the ROM and truncates.
    for (int i = 0; i < 20; i++) prog[i] = 8'($urandom);
    load_prog(DEPTH, 1'b1, 0);
    run_and_check(1, 1'b1);

    // Reset mid-load, then mid-run; each time reload from address 0.
    pulse_start();
    for (int i = 0; i < 3; i++) send_byte(prog[i], 1'b0, 0, i);
    @(posedge clk); #1;
    do_reset();
    load_prog(5, 1'b0, 0);
    @(negedge clk);
    @(posedge clk); #1;
    repeat (4) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("midrun_core_rst", longint'(core_rst), 0);
    @(posedge clk); #1;
    do_reset();
    load_prog(5, 1'b0, 2);
    run_and_check(10, 1'b0);

    // Randomized programs and run lengths.
    for (int it = 0; it < 10; it++) begin
      tr = ($urandom_range(0, 3) == 0);
      k  = tr ? DEPTH : int'($urandom_range(1, DEPTH));
      h  = int'($urandom_range(1, MAXC + 5));
      gm = int'($urandom_range(0, 2));
      for (int i = 0; i < k; i++) prog[i] = 8'($urandom);
      load_prog(k, tr, gm);
      run_and_check(h, tr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
